// File: rtl/pwm_if.sv
// Bundle between the angle-to-PWM controller (master) and the PWM output stage (slave).
// The dbg_* signals expose internal state of the stage for observation only.
interface pwm_if;
   // Four-phase level handshake: the master raises pwm_update with pwm_ratio stable,
   // the slave raises pwm_done once the ratio is active, the master drops pwm_update,
   // the slave drops pwm_done, and only then may a new request start.
   logic       pwm_enable;
   logic       pwm_update;
   logic [7:0] pwm_ratio;
   logic       pwm_done;
   logic       pwm_signal;
   logic       period_start;
   logic [1:0] dbg_state;
   logic [7:0] dbg_count;
   logic [7:0] dbg_active_ratio;

   modport master (
      output pwm_enable, pwm_update, pwm_ratio,
      input  pwm_done, pwm_signal, period_start,
      input  dbg_state, dbg_count, dbg_active_ratio
   );

   modport slave (
      input  pwm_enable, pwm_update, pwm_ratio,
      output pwm_done, pwm_signal, period_start,
      output dbg_state, dbg_count, dbg_active_ratio
   );
endinterface

// File: rtl/pwm_generator.sv
// Motor PWM output stage: prescaled period counter, double-buffered ratio, 4-phase apply ack.
// Define PWM_CENTER_ALIGNED_EN for up/down (centre-aligned) counting; default is edge-aligned.
module pwm_generator #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clock,
   input  logic reset,
   pwm_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      DONE    = 2'd2
   } state_e;

   localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

   state_e      state_q, state_d;
   logic [15:0] pre_q, pre_d;
   logic [7:0]  count_q, count_d;
   logic [7:0]  active_q, active_d;
   logic [7:0]  pending_q, pending_d;
   logic        fresh_q, fresh_d;
   logic        done_q, done_d;
   logic        sig_q, sig_d;
   logic        ps_q, ps_d;
   logic        tick;
   logic        boundary;
   logic        hit;

   assign tick = bus.pwm_enable && (pre_q == PRE_MAX);

`ifdef PWM_CENTER_ALIGNED_EN
   logic up_q, up_d;

   assign boundary = tick && !up_q && (count_q == 8'd1);
   assign hit      = (count_q < active_q) || (active_q == 8'hFF);
`else
   assign boundary = tick && (count_q == 8'd254);
   assign hit      = (count_q < active_q);
`endif

   // fresh_q marks the first tick after enable/reset: it starts a period at count 0
   // exactly like a boundary, so the counter holds 0 through that tick.
   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      fresh_d = fresh_q;
      ps_d    = 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
      up_d    = up_q;
`endif
      if (!bus.pwm_enable) begin
         pre_d   = 16'd0;
         count_d = 8'd0;
         fresh_d = 1'b1;
`ifdef PWM_CENTER_ALIGNED_EN
         up_d    = 1'b1;
`endif
      end else begin
         pre_d = tick ? 16'd0 : pre_q + 16'd1;
         if (tick) begin
            fresh_d = 1'b0;
            ps_d    = boundary || fresh_q;
            if (fresh_q) begin
               count_d = 8'd0;
            end else begin
`ifdef PWM_CENTER_ALIGNED_EN
               if (up_q) begin
                  count_d = count_q + 8'd1;
                  if (count_q == 8'd254) up_d = 1'b0;
               end else begin
                  count_d = count_q - 8'd1;
                  if (count_q == 8'd1) up_d = 1'b1;
               end
`else
               count_d = (count_q == 8'd254) ? 8'd0 : count_q + 8'd1;
`endif
            end
         end
      end
   end

   assign sig_d = bus.pwm_enable && hit;

   always_comb begin
      state_d   = state_q;
      pending_d = pending_q;
      active_d  = active_q;
      done_d    = done_q;
      case (state_q)
         IDLE: begin
            if (bus.pwm_update) begin
               pending_d = bus.pwm_ratio;
               state_d   = PENDING;
            end
         end
         PENDING: begin
            if (boundary || !bus.pwm_enable) begin
               active_d = pending_q;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: begin
            if (!bus.pwm_update) begin
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         pre_q     <= 16'd0;
         count_q   <= 8'd0;
         active_q  <= 8'd128;
         pending_q <= 8'd128;
         fresh_q   <= 1'b1;
         done_q    <= 1'b0;
         sig_q     <= 1'b0;
         ps_q      <= 1'b0;
`ifdef PWM_CENTER_ALIGNED_EN
         up_q      <= 1'b1;
`endif
      end else begin
         state_q   <= state_d;
         pre_q     <= pre_d;
         count_q   <= count_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         fresh_q   <= fresh_d;
         done_q    <= done_d;
         sig_q     <= sig_d;
         ps_q      <= ps_d;
`ifdef PWM_CENTER_ALIGNED_EN
         up_q      <= up_d;
`endif
      end
   end

   assign bus.pwm_done         = done_q;
   assign bus.pwm_signal       = sig_q;
   assign bus.period_start     = ps_q;
   assign bus.dbg_state        = state_q;
   assign bus.dbg_count        = count_q;
   assign bus.dbg_active_ratio = active_q;
endmodule

// File: tb/tb_pwm_generator.sv
// Bench for pwm_generator: two instances (PRESCALE 1 and 3) with a high-time scoreboard.
// Build with PWM_CENTER_ALIGNED_EN defined to exercise the centre-aligned variant.
module tb_pwm_generator;
`ifdef PWM_CENTER_ALIGNED_EN
   localparam int PERIOD = 510;
`else
   localparam int PERIOD = 255;
`endif

   logic clock = 1'b0;
   logic reset;
   logic sel;
   int   n_vec = 0;
   int   n_err = 0;
   logic [31:0] exp_q[$];

   always #5 clock = ~clock;

   pwm_if if1 ();
   pwm_if if3 ();

   pwm_generator #(.PRESCALE(1)) u_p1 (.clock(clock), .reset(reset), .bus(if1.slave));
   pwm_generator #(.PRESCALE(3)) u_p3 (.clock(clock), .reset(reset), .bus(if3.slave));

   logic s_ps, s_sig, s_done;
   always_comb begin
      s_ps   = sel ? if3.period_start : if1.period_start;
      s_sig  = sel ? if3.pwm_signal   : if1.pwm_signal;
      s_done = sel ? if3.pwm_done     : if1.pwm_done;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   // High clocks per period for a given ratio at PRESCALE 1.
   function automatic int high_ticks(input int r);
`ifdef PWM_CENTER_ALIGNED_EN
      if (r == 0) return 0;
      if (r == 255) return 510;
      return 2 * r - 1;
`else
      return r;
`endif
   endfunction

   function automatic int pre_of_sel();
      return sel ? 3 : 1;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d", tag, obs, exp);
      end
   endtask

   task automatic sb_check(input string tag, input int obs);
      logic [31:0] e;
      e = 32'hFFFF_FFFF;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check_eq(tag, obs, e);
   endtask

   task automatic drive_upd(input logic u, input logic [7:0] r);
      if (sel) begin
         if3.pwm_update = u;
         if3.pwm_ratio  = r;
      end else begin
         if1.pwm_update = u;
         if1.pwm_ratio  = r;
      end
   endtask

   task automatic wait_ps();
      int n = 0;
      int budget = PERIOD * pre_of_sel() + 10;
      while (!s_ps && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_eq("period_start_seen", 32'(s_ps), 32'd1);
   endtask

   // Samples len negedges after a period_start negedge; optionally raises an update mid-window.
   task automatic measure(input int len, input int upd_at, input int upd_ratio,
                          output int highs, output logic done_prev, output logic done_last);
      highs     = 0;
      done_prev = 1'b0;
      done_last = 1'b0;
      for (int i = 1; i <= len; i++) begin
         @(negedge clock);
         if (i == upd_at) drive_upd(1'b1, 8'(upd_ratio));
         highs += int'(s_sig);
         if (i == len - 1) done_prev = s_done;
         if (i == len) done_last = s_done;
      end
   endtask

   task automatic apply(input int r);
      int n = 0;
      int budget = PERIOD * pre_of_sel() + 10;
      @(negedge clock);
      drive_upd(1'b1, 8'(r));
      while (!s_done && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_eq("apply_done", 32'(s_done), 32'd1);
      drive_upd(1'b0, 8'(r));
      @(negedge clock);
      check_eq("apply_release", 32'(s_done), 32'd0);
   endtask

   initial begin
      int   h;
      int   n;
      int   r;
      logic dp, dl;

      sel = 1'b0;
      reset = 1'b1;
      if1.pwm_enable = 1'b1; if1.pwm_update = 1'b0; if1.pwm_ratio = 8'd128;
      if3.pwm_enable = 1'b0; if3.pwm_update = 1'b0; if3.pwm_ratio = 8'd128;
      repeat (3) @(negedge clock);
      check_eq("rst_done", 32'(if1.pwm_done), 32'd0);
      check_eq("rst_signal", 32'(if1.pwm_signal), 32'd0);
      check_eq("rst_period_start", 32'(if1.period_start), 32'd0);
      check_eq("rst_active", 32'(if1.dbg_active_ratio), 32'd128);
      check_eq("rst_state", 32'(if1.dbg_state), 32'd0);
      check_eq("rst_count", 32'(if1.dbg_count), 32'd0);
      reset = 1'b0;

      // Reset ratio of 128 over two periods.
      exp_q.push_back(32'(high_ticks(128)));
      exp_q.push_back(32'(high_ticks(128)));
      wait_ps();
      measure(PERIOD, -1, 0, h, dp, dl);
      sb_check("rst_period0_high", h);
      measure(PERIOD, -1, 0, h, dp, dl);
      sb_check("rst_period1_high", h);
      check_eq("rst_no_done", 32'(dl), 32'd0);

      // Mid-period update to 200: current period unchanged, done on the boundary edge.
      exp_q.push_back(32'(high_ticks(128)));
      wait_ps();
      measure(PERIOD, 50, 200, h, dp, dl);
      sb_check("glitch_cur_period_high", h);
      check_eq("glitch_done_before_boundary", 32'(dp), 32'd0);
      check_eq("glitch_done_at_boundary", 32'(dl), 32'd1);

      exp_q.push_back(32'(high_ticks(200)));
      fork
         begin
            int   hh;
            logic a, b;
            measure(PERIOD, -1, 0, hh, a, b);
            sb_check("glitch_new_period_high", hh);
         end
         begin
            int ok = 0;
            for (int k = 0; k < 10; k++) begin
               @(negedge clock);
               if (k == 2) drive_upd(1'b1, 8'd10);
               if (if1.pwm_done && if1.dbg_state == 2'd2) ok++;
            end
            check_eq("hs_hold_done", 32'(ok), 32'd10);
            drive_upd(1'b0, 8'd10);
            @(negedge clock);
            check_eq("hs_release_done", 32'(if1.pwm_done), 32'd0);
            check_eq("hs_release_state", 32'(if1.dbg_state), 32'd0);
            check_eq("hs_active_kept", 32'(if1.dbg_active_ratio), 32'd200);
         end
      join

      // Further ratios: a fixed one and two random ones.
      for (int j = 0; j < 3; j++) begin
         r = (j == 0) ? 100 : int'($urandom_range(1, 254));
         apply(r);
         exp_q.push_back(32'(high_ticks(r)));
         wait_ps();
         measure(PERIOD, -1, 0, h, dp, dl);
         sb_check("ratio_period_high", h);
      end

      // Disabled: handshake in two clocks, output low, counter held.
      @(negedge clock);
      if1.pwm_enable = 1'b0;
      @(negedge clock);
      drive_upd(1'b1, 8'd64);
      @(negedge clock);
      check_eq("dis_done_1clk", 32'(if1.pwm_done), 32'd0);
      @(negedge clock);
      check_eq("dis_done_2clk", 32'(if1.pwm_done), 32'd1);
      check_eq("dis_signal", 32'(if1.pwm_signal), 32'd0);
      check_eq("dis_count", 32'(if1.dbg_count), 32'd0);
      check_eq("dis_period_start", 32'(if1.period_start), 32'd0);
      drive_upd(1'b0, 8'd64);
      @(negedge clock);
      check_eq("dis_release", 32'(if1.pwm_done), 32'd0);
      if1.pwm_enable = 1'b1;
      @(negedge clock);
      check_eq("reen_period_start", 32'(if1.period_start), 32'd1);
      exp_q.push_back(32'(high_ticks(64)));
      measure(PERIOD, -1, 0, h, dp, dl);
      sb_check("reen_period_high", h);

      // Reset while PENDING aborts the request.
      @(negedge clock);
      drive_upd(1'b1, 8'd77);
      @(negedge clock);
      check_eq("rstp_pending", 32'(if1.dbg_state), 32'd1);
      reset = 1'b1;
      drive_upd(1'b0, 8'd77);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      check_eq("rstp_active", 32'(if1.dbg_active_ratio), 32'd128);
      n = 0;
      for (int k = 0; k < PERIOD + 10; k++) begin
         @(negedge clock);
         n += int'(if1.pwm_done);
      end
      check_eq("rstp_done_never", 32'(n), 32'd0);
      exp_q.push_back(32'(high_ticks(128)));
      wait_ps();
      measure(PERIOD, -1, 0, h, dp, dl);
      sb_check("rstp_period_high", h);

      // Extremes on the PRESCALE=3 instance.
      sel = 1'b1;
      @(negedge clock);
      if3.pwm_enable = 1'b1;
      apply(255);
      exp_q.push_back(32'(3 * 3 * high_ticks(255)));
      wait_ps();
      measure(3 * 3 * PERIOD, -1, 0, h, dp, dl);
      sb_check("p3_ratio255_high", h);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!s_ps && n < 4 * PERIOD);
      check_eq("p3_period_len", 32'(n), 32'(3 * PERIOD));
      apply(0);
      exp_q.push_back(32'(3 * 3 * high_ticks(0)));
      wait_ps();
      measure(3 * 3 * PERIOD, -1, 0, h, dp, dl);
      sb_check("p3_ratio0_high", h);

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/pwm_generator.md
# pwm_generator

Motor PWM output stage directly downstream of the angle-to-PWM controller. Consumes `pwm_enable`, `pwm_update` and `pwm_ratio` and drives the physical PWM pin for one swerve steering motor. Ratio changes are double-buffered and applied only on a PWM period boundary, so the output never glitches. Each application is acknowledged with `pwm_done` using a 4-phase handshake.

## Interface
- `PRESCALE`, default 1: clock cycles per PWM count tick (1–65535); a tick fires every `PRESCALE` clocks.
- `clock` input 1: main clock; everything is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `pwm_enable` input 1: 1 runs the PWM; 0 holds the counter and forces the output low.
- `pwm_update` input 1: request to apply `pwm_ratio`; level, held high until `pwm_done` is seen.
- `pwm_ratio` input 8: requested high-time out of 255; 128 is motor stop.
- `pwm_done` output 1: acknowledge that the captured ratio is now active; level.
- `pwm_signal` output 1: PWM pin.
- `period_start` output 1: one-clock pulse on the first tick of each period.

## Operation
- **Prescaler.** 16-bit counter 0..`PRESCALE`-1; `tick`=1 when it equals `PRESCALE`-1, then it wraps to 0.
- **Period counter.** 8-bit `count`, advanced on `tick`.
  - Edge-aligned: 0..254, then wraps to 0; period is 255 ticks.
  - Boundary = the tick on which `count` goes 254→0.
- **Output.** `pwm_signal` = `pwm_enable` & (`count` < `active_ratio`), registered.
  - Ratio 0 gives constant low; ratio 255 gives constant high.
- **Update FSM** (states IDLE, PENDING, DONE):
  - IDLE → PENDING when `pwm_update`=1: `pending_ratio` <= `pwm_ratio` on that edge.
  - PENDING → DONE on boundary tick, or on the next clock if `pwm_enable`=0: `active_ratio` <= `pending_ratio` and `pwm_done` <= 1 on that same edge.
  - DONE → IDLE when `pwm_update`=0 is sampled: `pwm_done` <= 0 on that edge.
- Changes to `pwm_ratio` while PENDING or DONE are ignored; the captured value is used.
- `pwm_update` held high in DONE does not start a new capture; the requester must drop it first.
- **Disabled** (`pwm_enable`=0):
  - Prescaler and `count` are held at 0; `period_start` is 0; `pwm_signal` is 0.
  - The FSM still runs, so handshakes complete.
- **Re-enable:** the first tick (`PRESCALE` clocks later) is count 0 and pulses `period_start`.
- **Reset.** Mid-operation reset aborts any PENDING request; a requester still holding `pwm_update` is re-captured in the first cycle after reset.
  - After reset: `pwm_signal`=0, `pwm_done`=0, `period_start`=0, `active_ratio`=128, `pending_ratio`=128, `count`=0, prescaler=0, FSM=IDLE.

## Timing
- `pwm_signal` lags `count` by one clock.
- Capture latency: 1 clock from `pwm_update` high to PENDING.
- Apply latency, enabled: at most 255×`PRESCALE`+1 clocks from `pwm_update` high to `pwm_done` high.
- Apply latency, disabled: 2 clocks from `pwm_update` high to `pwm_done` high.
- New ratio is visible on `pwm_signal` in the period that starts at the boundary (one clock later).
- Handshake release: `pwm_done` falls 1 clock after `pwm_update` is sampled low.
- Minimum full handshake cycle is 4 clocks.
- Simultaneous events:
  - Boundary tick in IDLE with `pwm_update` rising: capture only; apply at the next boundary.
  - Boundary in PENDING together with `pwm_enable` falling: apply once, on that edge.

## Configuration
- `PWM_CENTER_ALIGNED_EN` undefined: edge-aligned behaviour as above.
- `PWM_CENTER_ALIGNED_EN` defined: `count` runs up/down 0,1,…,254,255,254,…,1,0; period is 510 ticks.
  - Boundary and `period_start` are the tick on which `count` goes 1→0.
  - `pwm_signal` = `pwm_enable` & ((`count` < `active_ratio`) | (`active_ratio`==255)).
  - High pulse is centred on count 0 with width 2×ratio−1 ticks.
  - Worst-case apply latency becomes 510×`PRESCALE`+1 clocks.
  - Reset and disable behaviour are unchanged, including direction reset to up.

## Test plan
- **Reset values.** Reset asserted for 3 clocks, `PRESCALE`=1, enable=1 → `pwm_signal` high for exactly 128 of every 255 clocks; `pwm_done`=0.
- **Glitch-free apply.** Ratio 200 updated mid-period at count 50 → the current period still shows 128 high ticks; `pwm_done` rises on the boundary edge; the next period shows 200 high.
- **Handshake.** Hold `pwm_update` for 10 clocks after done, with `pwm_ratio` changed to 10 during DONE → no second capture, done stays high; it falls 1 clock after update drops; active ratio stays 200.
- **Extremes.** Ratio 0 → `pwm_signal` constantly 0; ratio 255 → constantly 1 across 3 periods, with `PRESCALE`=3 → period of 765 clocks.
- **Disable and reset.** `pwm_enable`=0 plus update to 64 → done 2 clocks later, output 0. Re-enable → `period_start` after `PRESCALE` clocks, 64 high ticks. Reset asserted during PENDING → done never rises and ratio returns to 128.
- **Centre-aligned** (macro defined): ratio 100, `PRESCALE`=1 → period 510 clocks, high pulse 199 clocks centred on count 0, `pwm_done` on the 1→0 tick.
